pg_prefix_add_pipe: RTL and testbench

- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor for the SAD datapath.
- Generalises the 32-bit propagate/generate front end to any WIDTH.
- Adds the full prefix carry tree, configurable pipeline depth, an add/sub mode and a valid/ready stream interface.
- Sits between the pixel-difference stage and the SAD accumulator.

---
 rtl/pg_prefix_add_pipe_if.sv | 38 +++
 rtl/pg_prefix_add_pipe.sv | 195 +++++++++++++++++++
 tb/tb_pg_prefix_add_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pg_prefix_add_pipe_if.sv
// Valid/ready stream interface for pg_prefix_add_pipe.
// The in_abs input exists only when PG_PREFIX_ABS_DIFF_EN is defined.
interface pg_prefix_add_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
`ifdef PG_PREFIX_ABS_DIFF_EN
    logic             in_abs;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_abs, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_abs, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`endif
endinterface

// File: rtl/pg_prefix_add_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready stream.
// Optional feature macro: PG_PREFIX_ABS_DIFF_EN adds a second B-A tree and the
// in_abs input so a subtract can return |A-B|.
// The carry-in is folded into bit 0's generate at the input stage, so after the
// last prefix level G[i] is the carry out of bit i. The final register stores the
// finished sum/flags, keeping every output register-driven.
module pg_prefix_add_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic                clk,
    input  logic                rst,
    pg_prefix_add_pipe_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);
    // Per-level state word: {c0, original p, group P, group G}
    localparam int SW    = 3 * WIDTH + 1;
`ifdef PG_PREFIX_ABS_DIFF_EN
    localparam int NT    = 2;
`else
    localparam int NT    = 1;
`endif
    // Control word per level: bit 0 valid, bit 1 (abs builds only) pick |A-B|
    localparam int MW    = NT;

    logic                     stall_s;
    logic [MW-1:0]            meta_in_s;
    logic [MW-1:0]            meta0_r;
    logic [MW-1:0]            meta_s [0:LOG2W-1];
    logic [NT-1:0][WIDTH-1:0] tsum_s;
    logic                     cout_s;
    logic                     ovf_s;
    logic [WIDTH-1:0]         sel_sum_s;
    logic                     out_valid_r;
    logic [WIDTH-1:0]         out_sum_r;
    logic                     out_cout_r;
    logic                     out_ovf_r;

    assign stall_s      = out_valid_r & ~bus.out_ready;
    assign bus.in_ready = ~stall_s;

`ifdef PG_PREFIX_ABS_DIFF_EN
    assign meta_in_s = {bus.in_abs & bus.in_sub, bus.in_valid};
`else
    assign meta_in_s = bus.in_valid;
`endif

    // Input-stage control register; a bubble enters whenever no beat is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            meta0_r <= {MW{1'b0}};
        end else if (!stall_s) begin
            meta0_r <= meta_in_s;
        end
    end
    assign meta_s[0] = meta0_r;

    // Control words follow the same register placement as the prefix data
    for (genvar k = 0; k < LOG2W - 1; k++) begin : g_meta
        if (((k + 1) % PIPE_EVERY) == 0) begin : g_reg
            logic [MW-1:0] meta_r;
            // Level-boundary control register, frozen during a stall
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_r <= {MW{1'b0}};
                end else if (!stall_s) begin
                    meta_r <= meta_s[k];
                end
            end
            assign meta_s[k+1] = meta_r;
        end else begin : g_wire
            assign meta_s[k+1] = meta_s[k];
        end
    end

    // Tree 0 computes A+B+cin or A-B; tree 1 (abs builds) computes B-A
    for (genvar t = 0; t < NT; t++) begin : g_tree
        logic [SW-1:0]    lv_s [0:LOG2W-1];
        logic [SW-1:0]    st0_r;
        logic [WIDTH-1:0] x_s;
        logic [WIDTH-1:0] y_s;
        logic [WIDTH-1:0] p0_s;
        logic [WIDTH-1:0] g0_s;
        logic             c0_s;

        if (t == 0) begin : g_ab
            assign x_s  = bus.in_a;
            assign y_s  = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign c0_s = bus.in_sub | bus.in_cin;
        end else begin : g_ba
            assign x_s  = bus.in_b;
            assign y_s  = ~bus.in_a;
            assign c0_s = 1'b1;
        end

        assign p0_s = x_s ^ y_s;
        assign g0_s = (x_s & y_s) | {{(WIDTH-1){1'b0}}, p0_s[0] & c0_s};

        // Input-stage data register; only reloads on an accepted beat
        always_ff @(posedge clk) begin
            if (rst) begin
                st0_r <= {SW{1'b0}};
            end else if (!stall_s && bus.in_valid) begin
                st0_r <= {c0_s, p0_s, p0_s, g0_s};
            end
        end
        assign lv_s[0] = st0_r;

        // All prefix levels but the last; spans past the MSB fall off the shift
        for (genvar k = 0; k < LOG2W - 1; k++) begin : g_lvl
            localparam int               SPAN     = int'(32'd1 << k);
            localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - SPAN);
            logic [WIDTH-1:0] g_s;
            logic [WIDTH-1:0] p_s;
            logic [WIDTH-1:0] gn_s;
            logic [WIDTH-1:0] pn_s;
            logic [SW-1:0]    nx_s;

            assign g_s  = lv_s[k][WIDTH-1:0];
            assign p_s  = lv_s[k][2*WIDTH-1:WIDTH];
            assign gn_s = g_s | (p_s & (g_s << SPAN));
            assign pn_s = p_s & ((p_s << SPAN) | LOW_MASK);
            assign nx_s = {lv_s[k][SW-1:2*WIDTH], pn_s, gn_s};

            if (((k + 1) % PIPE_EVERY) == 0) begin : g_reg
                logic [SW-1:0] lv_r;
                // Level-boundary data register, frozen during a stall
                always_ff @(posedge clk) begin
                    if (rst) begin
                        lv_r <= {SW{1'b0}};
                    end else if (!stall_s) begin
                        lv_r <= nx_s;
                    end
                end
                assign lv_s[k+1] = lv_r;
            end else begin : g_wire
                assign lv_s[k+1] = nx_s;
            end
        end

        // Last level needs only G; it feeds the sum directly
        localparam int SPAN_L = int'(32'd1 << (LOG2W - 1));
        logic [WIDTH-1:0] gl_s;
        logic [WIDTH-1:0] pl_s;
        logic [WIDTH-1:0] po_s;
        logic [WIDTH-1:0] gf_s;
        logic             c0l_s;

        assign gl_s      = lv_s[LOG2W-1][WIDTH-1:0];
        assign pl_s      = lv_s[LOG2W-1][2*WIDTH-1:WIDTH];
        assign po_s      = lv_s[LOG2W-1][3*WIDTH-1:2*WIDTH];
        assign c0l_s     = lv_s[LOG2W-1][SW-1];
        assign gf_s      = gl_s | (pl_s & (gl_s << SPAN_L));
        assign tsum_s[t] = po_s ^ {gf_s[WIDTH-2:0], c0l_s};

        if (t == 0) begin : g_flags
            assign cout_s = gf_s[WIDTH-1];
            assign ovf_s  = gf_s[WIDTH-1] ^ gf_s[WIDTH-2];
        end
    end

    // Result select: B-A replaces A-B when |A-B| is requested and A < B
    always_comb begin
        sel_sum_s = tsum_s[0];
`ifdef PG_PREFIX_ABS_DIFF_EN
        if (meta_s[LOG2W-1][1] && !cout_s) begin
            sel_sum_s = tsum_s[1];
        end else begin
            sel_sum_s = tsum_s[0];
        end
`endif
    end

    // Output register; result fields only change when a valid beat lands
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= meta_s[LOG2W-1][0];
            if (meta_s[LOG2W-1][0]) begin
                out_sum_r  <= sel_sum_s;
                out_cout_r <= cout_s;
                out_ovf_r  <= ovf_s;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_pg_prefix_add_pipe.sv
// Randomised and directed bench for pg_prefix_add_pipe (WIDTH=32, PIPE_EVERY=2).
module tb_pg_prefix_add_pipe;
    localparam int W   = 32;
    localparam int PE  = 2;
    localparam int LAT = 4;

    logic clk;
    logic rst;
    logic drv_abs;
    int   n_total;
    int   n_bad;
    int   n_xfer;
    int   n_stall;
    logic [33:0] exp_q [$];
    logic [33:0] mon_e;

    pg_prefix_add_pipe_if #(.WIDTH(W)) bus ();

    pg_prefix_add_pipe #(.WIDTH(W), .PIPE_EVERY(PE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PG_PREFIX_ABS_DIFF_EN
    assign bus.in_abs = drv_abs;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub, input logic ab);
        longint ua, ub, us, sa, sb, ss;
        logic [31:0] sum;
        logic        cout, ovf;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            us   = ua - ub;
            ss   = sa - sb;
            cout = (ua >= ub);
        end else begin
            us   = ua + ub + longint'(cin);
            ss   = sa + sb + longint'(cin);
            cout = (us > 64'sd4294967295);
        end
        sum = us[31:0];
        if (sub && ab && (ua < ub)) sum = b - a;
        ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {ovf, cout, sum};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(7))
            0: return 32'hFFFF_FFFF;
            1: return 32'h0000_0000;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: predicted on accept, compared in order on transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("sum",  bus.out_sum,  mon_e[31:0]);
                    check_eq("cout", bus.out_cout, mon_e[32]);
                    check_eq("ovf",  bus.out_ovf,  mon_e[33]);
                end
            end
            if (!bus.in_ready) n_stall++;
            check_eq("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, drv_abs));
        end
    end

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int   waited;
        logic ok;
        bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
        bus.in_valid = 1'b1;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        check_eq("accepted", ok, 1'b1);
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, input logic [31:0] es, input logic ec, input logic eo);
        int n;
        send_beat(a, b, cin, sub);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check_eq({tag, "_lat"},  n, LAT);
        check_eq({tag, "_sum"},  bus.out_sum, es);
        check_eq({tag, "_cout"}, bus.out_cout, ec);
        check_eq({tag, "_ovf"},  bus.out_ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, s0;
        bit drv_done;
        n_total = 0; n_bad = 0; n_xfer = 0; n_stall = 0;
        rst = 1'b1; drv_abs = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0;
        bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_valid", bus.out_valid, 1'b0);
            check_eq("idle_sum",   bus.out_sum, 32'd0);
            check_eq("idle_ready", bus.in_ready, 1'b1);
        end
        @(posedge clk); #1;

        // Directed corner cases
        run_one("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_neg",32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run_one("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_one("sub_eq", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_cin",32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
`ifdef PG_PREFIX_ABS_DIFF_EN
        drv_abs = 1'b1;
        run_one("abs_lt", 32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
        run_one("abs_ge", 32'h0000_0009, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        drv_abs = 1'b0;
`endif

        // Eight back-to-back beats with a three-cycle output stall
        x0 = n_xfer; s0 = n_stall;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_beat($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check_eq("stream_count", n_xfer - x0, 8);
        check_eq("stream_stall", n_stall - s0, 3);

        // Randomised traffic with random back-pressure and gaps
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
`ifdef PG_PREFIX_ABS_DIFF_EN
                    drv_abs = 1'($urandom_range(1));
`endif
                    send_beat(pick_op(), pick_op(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        drv_abs = 1'b0;

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_eq("post_rst_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_one("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
